// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the stream_mux_rr block and its arbiter.
//   MODE_RR / MODE_SEL : encodings of the 'mode' input
//   DEFAULT_WIDTH      : default data width per channel
//   wrap_next()        : next round-robin start index after a grant
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_RR       = 1'b0;
    localparam logic MODE_SEL      = 1'b1;
    localparam int   DEFAULT_WIDTH = 16;

    // Index following 'g' in a ring of 'n' channels.
    function automatic int wrap_next(input int g, input int n);
        int r;
        if (g >= n - 1) begin
            r = 0;
        end else begin
            r = g + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans req starting at ptr and
// wrapping modulo N; the first requesting channel wins.
// Ports:
//   req         in  N     request per channel
//   ptr         in  SELW  channel with highest priority this cycle
//   grant       out SELW  index of the winning channel (0 when none)
//   grant_valid out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    // Rotating priority scan; the found flag freezes the first hit.
    always_comb begin
        grant       = {SELW{1'b0}};
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end else begin
                grant       = grant;
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Channel choice is round-robin (mode = MODE_RR) or an explicit index
// (mode = MODE_SEL). One word per cycle is sustained while out_ready is high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_data     N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid    N        per-channel valid
//   in_ready    N        per-channel ready (combinational, one-hot or zero)
//   mode        1        0 = round-robin, 1 = explicit select
//   sel         SELW     channel index used in select mode
//   out_data    WIDTH    registered data
//   out_valid   1        registered valid
//   out_ready   1        consumer ready
//   out_chan    SELW     registered index of the producing channel
// -----------------------------------------------------------------------------
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [SELW-1:0]  rr_grant_s;
    logic             rr_grant_valid_s;
    logic             sel_grant_valid_s;
    logic [SELW-1:0]  grant_s;
    logic             grant_valid_s;
    logic             load_en_s;
    logic             xfer_s;
    logic [WIDTH-1:0] grant_data_s;

    rr_arbiter #(.N(N)) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant_s),
        .grant_valid (rr_grant_valid_s)
    );

    // Explicit-select hit; an index with no matching channel (sel >= N) never hits.
    always_comb begin
        sel_grant_valid_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel_grant_valid_s = sel_grant_valid_s | ((sel == SELW'(i)) & in_valid[i]);
        end
    end

    // Mode mux: pick which grant source drives the handshake this cycle.
    always_comb begin
        case (mode)
            MODE_RR: begin
                grant_s       = rr_grant_s;
                grant_valid_s = rr_grant_valid_s;
            end
            MODE_SEL: begin
                grant_s       = sel;
                grant_valid_s = sel_grant_valid_s;
            end
            default: begin
                grant_s       = {SELW{1'b0}};
                grant_valid_s = 1'b0;
            end
        endcase
    end

    assign load_en_s = !valid_q || out_ready;
    assign xfer_s    = load_en_s && grant_valid_s;

    // Per-channel ready; gated by rst_n so nothing is accepted during reset.
    always_comb begin
        in_ready = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && load_en_s && grant_valid_s && (grant_s == SELW'(i));
        end
    end

    // Data of the granted channel, selected by loop so no out-of-range slice exists.
    always_comb begin
        grant_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant_s == SELW'(i)) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    // Next state of output register and round-robin pointer.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer_s) begin
            data_d  = grant_data_s;
            chan_d  = grant_s;
            valid_d = 1'b1;
            ptr_d   = SELW'(wrap_next(int'(grant_s), N));
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; an asynchronous reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {WIDTH{1'b0}};
            chan_q  <= {SELW{1'b0}};
            valid_q <= 1'b0;
            ptr_q   <= {SELW{1'b0}};
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule
